demux_stream_1_n: RTL and testbench
===================================

// Module: demux_stream_1_n
// PURPOSE
//  Registered 1-to-N demultiplexer: the inverse of our 2:1 mux path. One input stream with
//  valid/ready is steered by a select value to one of N_OUT output streams. Each output owns a
//  one-entry holding register, so a stalled output does not block traffic to the other outputs.
//  Sits between a producer and N consumers.
// PARAMETERS
//  N_OUT   2  number of output channels (2..16)
//  DATA_W  8  data width in bits
//  SEL_W   1  select width; must satisfy 2**SEL_W >= N_OUT
//  CNT_W   8  width of the bad-select counter
// PORTS
//  CLK   in   1             rising-edge clock
//  RST   in   1             synchronous reset, active-high
//  I     in   DATA_W        input data
//  S     in   SEL_W         destination select; sampled with I
//  IV    in   1             input valid
//  IR    out  1             input ready
//  Y     out  N_OUT*DATA_W  output data; channel k occupies bits [k*DATA_W +: DATA_W]
//  YV    out  N_OUT         per-channel output valid
//  YR    in   N_OUT         per-channel output ready
//  ERR   out  CNT_W         count of accepted beats whose S >= N_OUT
// BEHAVIOUR
//  - Reset (RST=1 at a CLK edge): all slots EMPTY. Y=0, YV=0, ERR=0.
//    IR is driven 0 during the reset cycle. Reset mid-transfer discards any held beats.
//  - Per-slot FSM, 2 states:
//    - EMPTY->FULL on load.
//    - FULL->EMPTY on drain (YV[k]&YR[k]) without a load.
//    - FULL->FULL on drain with a simultaneous load: the new beat replaces the old one.
//  - IR is combinational from S, the slot state and YR:
//    - S < N_OUT: IR = !RST & (slot[S] EMPTY | YR[S]).
//    - S >= N_OUT: IR = !RST.
//  - Accept = IV & IR. On accept with S < N_OUT: Y[S] <= I and YV[S] <= 1 at the next edge.
//    Latency is exactly 1 cycle. Sustained throughput is 1 beat/cycle to a channel with YR held 1.
//  - On accept with S >= N_OUT: the beat is dropped and ERR increments.
//    ERR saturates at 2**CNT_W-1 and never wraps.
//  - Y[k] holds its value while YV[k]=1 and YR[k]=0. Y[k] retains its last value after a drain;
//    it is not cleared.
//  - Only one slot is loaded per cycle. Any number of slots may drain in the same cycle.
//  - Producer rule: I and S must stay stable while IV=1 and IR=0. A change to S while stalled is a
//    protocol violation; the block then behaves per the current S and no extra check is made.
//  - No combinational path from I to Y. There is a combinational path from YR and S to IR.
// STRUCTURE
//  - Package demux_pkg holds:
//    - typedef slot_state_t {SLOT_EMPTY, SLOT_FULL};
//    - the localparam check function clog2_ok(N_OUT, SEL_W), used for the elaboration-time
//      assertion.
//  - Sub-module demux_slot (one per channel, via generate) contains the FULL/EMPTY state, the data
//    register and the valid/ready logic.
//    - Ports: CLK, RST, LD, D, YV, YR, Y, RDY.
//    - RDY = EMPTY | YR.
//  - The top level contains select decode, IR mux, ERR counter and output concatenation.
// TESTING
//  - Reset check: RST=1 for 2 cycles with IV=1, I=8'hAA, S=0.
//    -> IR=0 throughout, YV=2'b00, ERR=0. After release, the first accept happens in the next
//    cycle.
//  - Basic steer: YR=2'b11. Drive I=8'h11,S=0 then I=8'h22,S=1, one cycle each.
//    -> One cycle later YV=2'b01 with Y[0]=8'h11, then YV=2'b10 with Y[1]=8'h22.
//  - Backpressure isolation: YR=2'b00. Send 8'h33 to ch0, then 8'h44 to ch0.
//    -> The second beat stalls (IR=0). 8'h55 to ch1 is accepted in the same period.
//    -> After YR[0]=1 for one cycle, 8'h44 loads and Y[0] holds 8'h44 until drained.
//  - Drain+load same cycle: ch0 FULL with 8'h66, YR[0]=1, IV=1, I=8'h77, S=0.
//    -> IR=1 and YV[0] stays 1. Next cycle Y[0]=8'h77. Exactly 2 beats observed on ch0.
//  - Bad select: N_OUT=3, SEL_W=2, CNT_W=2. Send 5 beats with S=3.
//    -> IR=1 for each, no YV pulse. ERR goes 1,2,3,3,3 (saturates).
//  - Reset mid-operation: ch0 and ch1 FULL, ERR=2. Assert RST for 1 cycle.
//    -> YV=0, ERR=0. Old data never appears as valid afterward.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and the elaboration-time configuration check for the 1-to-N stream demux.
package demux_pkg;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  // Legal when the channel count is in range and the select can address every channel.
  function automatic bit clog2_ok(input int n_out, input int sel_w);
    return (n_out >= 2) && (n_out <= 16) && ((1 << sel_w) >= n_out);
  endfunction

endpackage

// File: rtl/demux_stream_1_n_if.sv
// Producer-side stream plus the N consumer-side streams and the bad-select counter.
interface demux_stream_1_n_if #(
  parameter int N_OUT  = 2,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0]       i;
  logic [SEL_W-1:0]        s;
  logic                    iv;
  logic                    ir;
  logic [N_OUT*DATA_W-1:0] y;
  logic [N_OUT-1:0]        yv;
  logic [N_OUT-1:0]        yr;
  logic [CNT_W-1:0]        err;

  modport master (output i, s, iv, yr, input ir, y, yv, err);
  modport slave  (input i, s, iv, yr, output ir, y, yv, err);
endinterface

// File: rtl/demux_stream_1_n_slot.sv
// One-entry holding register for a single output channel.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic              yv,
  input  logic              yr,
  output logic [DATA_W-1:0] y,
  output logic              rdy
);

  slot_state_t st, st_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= SLOT_EMPTY;
      y  <= '0;
    end else begin
      st <= st_nx;
      if (ld) y <= d;
    end
  end

  // A load while draining keeps the slot full with the new beat.
  always_comb begin
    st_nx = st;
    case (st)
      SLOT_EMPTY: if (ld) st_nx = SLOT_FULL;
      SLOT_FULL:  if (yr && !ld) st_nx = SLOT_EMPTY;
      default:    st_nx = SLOT_EMPTY;
    endcase
  end

  assign yv  = (st == SLOT_FULL);
  assign rdy = (st == SLOT_EMPTY) || yr;

endmodule

// File: rtl/demux_stream_1_n.sv
// Registered 1-to-N stream demux: select decode, ready mux, bad-select counter, slot array.
module demux_stream_1_n
  import demux_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst,
  demux_stream_1_n_if.slave bus
);

  if (!clog2_ok(N_OUT, SEL_W)) begin : g_bad_cfg
    $error("demux_stream_1_n: N_OUT must be 2..16 and addressable by SEL_W");
  end

  logic [N_OUT-1:0]             hit, ld, rdy, yv;
  logic [N_OUT-1:0][DATA_W-1:0] ydat;
  logic                         sel_rdy, acc, bad;
  logic [CNT_W-1:0]             err_q;

  // Selects with no matching channel are always ready so they can be dropped.
  always_comb begin
    hit     = '0;
    sel_rdy = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.s == SEL_W'(k)) begin
        hit[k]  = 1'b1;
        sel_rdy = rdy[k];
      end
    end
  end

  assign bus.ir = !rst && sel_rdy;
  assign acc    = bus.iv && bus.ir;
  assign ld     = {N_OUT{acc}} & hit;
  assign bad    = acc && (hit == '0);

  always_ff @(posedge clk) begin
    if (rst)                       err_q <= '0;
    else if (bad && err_q != '1)   err_q <= err_q + 1'b1;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk (clk),
      .rst (rst),
      .ld  (ld[k]),
      .d   (bus.i),
      .yv  (yv[k]),
      .yr  (bus.yr[k]),
      .y   (ydat[k]),
      .rdy (rdy[k])
    );
  end

  assign bus.y   = ydat;
  assign bus.yv  = yv;
  assign bus.err = err_q;

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Bench: vector table on a 2-channel instance, corner sequences and a randomized
// model comparison on a 3-channel instance with an unused select code.
module tb_demux_stream_1_n;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  demux_stream_1_n_if #(.N_OUT(2), .DATA_W(8), .SEL_W(1), .CNT_W(8)) bus_a ();
  demux_stream_1_n_if #(.N_OUT(3), .DATA_W(8), .SEL_W(2), .CNT_W(2)) bus_b ();

  demux_stream_1_n #(.N_OUT(2), .DATA_W(8), .SEL_W(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a));
  demux_stream_1_n #(.N_OUT(3), .DATA_W(8), .SEL_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b));

  int errors = 0;
  int checks = 0;
  int beats0 = 0;

  always @(posedge clk) if (bus_a.yv[0] && bus_a.yr[0]) beats0 <= beats0 + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, iv;
    logic [7:0] i;
    logic       s;
    logic [1:0] yr;
    logic       ir;
    logic [1:0] yv;
    logic [7:0] y0, y1, err;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic r, iv, input logic [7:0] d, input logic sel,
                     input logic [1:0] yrv, input logic eir, input logic [1:0] eyv,
                     input logic [7:0] ey0, ey1, eerr);
    vec_t v;
    v = '{rst: r, iv: iv, i: d, s: sel, yr: yrv, ir: eir, yv: eyv, y0: ey0, y1: ey1, err: eerr};
    tab.push_back(v);
  endtask

  task automatic cyc_b(input logic r, iv, input logic [7:0] d, input logic [1:0] sel,
                       input logic [2:0] yrv, input logic eir, input string nm);
    @(negedge clk);
    rst_b = r; bus_b.iv = iv; bus_b.i = d; bus_b.s = sel; bus_b.yr = yrv;
    #1 chk({nm, ".ir"}, 32'(bus_b.ir), 32'(eir));
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 3-channel instance.
  logic       mf[3];
  logic [7:0] md[3];
  int         merr;

  initial begin
    int snap;
    logic r, iv, eir;
    logic [7:0] d;
    logic [1:0] sel;
    logic [2:0] yrv;

    bus_a.iv = 0; bus_a.i = 0; bus_a.s = 0; bus_a.yr = 0;
    bus_b.iv = 0; bus_b.i = 0; bus_b.s = 0; bus_b.yr = 0;

    //   rst iv  i      s  yr     ir  yv     y0     y1     err
    add(1, 1, 8'hAA, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 8'h0);
    add(1, 1, 8'hAA, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 8'h0);
    add(0, 1, 8'hAA, 0, 2'b00, 1, 2'b01, 8'hAA, 8'h00, 8'h0);
    add(0, 0, 8'h00, 0, 2'b01, 1, 2'b00, 8'hAA, 8'h00, 8'h0);
    add(0, 1, 8'h11, 0, 2'b11, 1, 2'b01, 8'h11, 8'h00, 8'h0);
    add(0, 1, 8'h22, 1, 2'b11, 1, 2'b10, 8'h11, 8'h22, 8'h0);
    add(0, 0, 8'h00, 0, 2'b11, 1, 2'b00, 8'h11, 8'h22, 8'h0);
    add(0, 1, 8'h33, 0, 2'b00, 1, 2'b01, 8'h33, 8'h22, 8'h0);
    add(0, 1, 8'h44, 0, 2'b00, 0, 2'b01, 8'h33, 8'h22, 8'h0);
    add(0, 1, 8'h55, 1, 2'b00, 1, 2'b11, 8'h33, 8'h55, 8'h0);
    add(0, 1, 8'h44, 0, 2'b01, 1, 2'b11, 8'h44, 8'h55, 8'h0);
    add(0, 0, 8'h00, 0, 2'b00, 0, 2'b11, 8'h44, 8'h55, 8'h0);
    add(0, 0, 8'h00, 0, 2'b11, 1, 2'b00, 8'h44, 8'h55, 8'h0);
    add(0, 1, 8'h66, 0, 2'b00, 1, 2'b01, 8'h66, 8'h55, 8'h0);
    add(0, 1, 8'h77, 0, 2'b01, 1, 2'b01, 8'h77, 8'h55, 8'h0);
    add(0, 0, 8'h00, 0, 2'b01, 1, 2'b00, 8'h77, 8'h55, 8'h0);
    add(0, 1, 8'h88, 0, 2'b00, 1, 2'b01, 8'h88, 8'h55, 8'h0);
    add(0, 1, 8'h99, 1, 2'b00, 1, 2'b11, 8'h88, 8'h99, 8'h0);
    add(1, 0, 8'h00, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 8'h0);
    add(0, 0, 8'h00, 0, 2'b11, 1, 2'b00, 8'h00, 8'h00, 8'h0);
    add(0, 0, 8'h00, 1, 2'b11, 1, 2'b00, 8'h00, 8'h00, 8'h0);

    snap = 0;
    for (int n = 0; n < tab.size(); n++) begin
      @(negedge clk);
      rst_a = tab[n].rst; bus_a.iv = tab[n].iv; bus_a.i = tab[n].i;
      bus_a.s = tab[n].s; bus_a.yr = tab[n].yr;
      if (n == 13) snap = beats0;
      #1 chk($sformatf("vec%0d.ir", n), 32'(bus_a.ir), 32'(tab[n].ir));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.yv", n),  32'(bus_a.yv),      32'(tab[n].yv));
      chk($sformatf("vec%0d.y0", n),  32'(bus_a.y[7:0]),  32'(tab[n].y0));
      chk($sformatf("vec%0d.y1", n),  32'(bus_a.y[15:8]), 32'(tab[n].y1));
      chk($sformatf("vec%0d.err", n), 32'(bus_a.err),     32'(tab[n].err));
      if (n == 15) chk("drain_load.beats", 32'(beats0 - snap), 32'd2);
    end

    // Bad select saturation on the 3-channel instance.
    cyc_b(1, 0, 8'h00, 2'd0, 3'b000, 1'b0, "bad.rst");
    for (int n = 1; n <= 5; n++) begin
      cyc_b(0, 1, 8'hC0 + 8'(n), 2'd3, 3'b000, 1'b1, $sformatf("bad%0d", n));
      chk($sformatf("bad%0d.yv", n),  32'(bus_b.yv),  32'd0);
      chk($sformatf("bad%0d.err", n), 32'(bus_b.err), (n < 3) ? 32'(n) : 32'd3);
    end

    // Reset with held beats and a nonzero error count.
    cyc_b(1, 0, 8'h00, 2'd0, 3'b000, 1'b0, "mid.rst0");
    cyc_b(0, 1, 8'h00, 2'd3, 3'b000, 1'b1, "mid.bad0");
    cyc_b(0, 1, 8'h00, 2'd3, 3'b000, 1'b1, "mid.bad1");
    cyc_b(0, 1, 8'hA1, 2'd0, 3'b000, 1'b1, "mid.ld0");
    cyc_b(0, 1, 8'hB2, 2'd1, 3'b000, 1'b1, "mid.ld1");
    chk("mid.full_yv", 32'(bus_b.yv),  32'b011);
    chk("mid.err2",    32'(bus_b.err), 32'd2);
    cyc_b(1, 0, 8'h00, 2'd0, 3'b000, 1'b0, "mid.rst1");
    chk("mid.rst_yv",  32'(bus_b.yv),  32'd0);
    chk("mid.rst_err", 32'(bus_b.err), 32'd0);
    chk("mid.rst_y",   32'(bus_b.y),   32'd0);
    for (int n = 0; n < 2; n++) begin
      cyc_b(0, 0, 8'h00, 2'(n), 3'b111, 1'b1, $sformatf("mid.post%0d", n));
      chk($sformatf("mid.post%0d.yv", n), 32'(bus_b.yv), 32'd0);
    end

    // Randomized traffic against the model, starting from reset.
    cyc_b(1, 0, 8'h00, 2'd0, 3'b000, 1'b0, "rnd.rst");
    for (int k = 0; k < 3; k++) begin mf[k] = 0; md[k] = 0; end
    merr = 0;
    for (int c = 0; c < 400; c++) begin
      r   = ($urandom_range(0, 49) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      yrv = 3'($urandom);
      if (r)             eir = 0;
      else if (sel >= 3) eir = 1;
      else               eir = !mf[sel] || yrv[sel];
      cyc_b(r, iv, d, sel, yrv, eir, $sformatf("rnd%0d", c));
      if (r) begin
        for (int k = 0; k < 3; k++) begin mf[k] = 0; md[k] = 0; end
        merr = 0;
      end else begin
        for (int k = 0; k < 3; k++) if (mf[k] && yrv[k]) mf[k] = 0;
        if (iv && eir) begin
          if (sel < 3) begin mf[sel] = 1; md[sel] = d; end
          else if (merr < 3) merr++;
        end
      end
      chk($sformatf("rnd%0d.yv", c), 32'(bus_b.yv), 32'({mf[2], mf[1], mf[0]}));
      chk($sformatf("rnd%0d.y", c),  32'(bus_b.y),  32'({md[2], md[1], md[0]}));
      chk($sformatf("rnd%0d.err", c), 32'(bus_b.err), 32'(merr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
